cell_tester: RTL and testbench
==============================

# cell_tester

Stimulus sequencer and response reader for the standard-cell characterisation array. It drives the array's 6-bit input bus and waits a programmable settle time. It then captures the array's 73-bit response and streams it out as byte frames over a valid/ready interface toward the chip's output pins. It runs either a single vector or a full 64-vector sweep.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: clock cycles each vector is held before capture. Legal range is 1..255; a value of 0 is treated as 1.
- `IN_W`, default 6: stimulus width. Fixed; the block is not generic in it.
- `RESP_W`, default 73: response width. Fixed; the block is not generic in it.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `start_i`, in, 1: one-cycle start request. Sampled only in IDLE.
- `sweep_i`, in, 1: sampled with `start_i`. 1 = sweep vectors 0..63; 0 = single vector.
- `vec_i`, in, 6: the vector used in single mode. Sampled with `start_i`.
- `cells_in_o`, out, 6: stimulus to the cell array.
- `cells_out_i`, in, 73: response from the cell array. Treated as quasi-static after the settle time.
- `byte_o`, out, 8: frame byte.
- `byte_valid_o`, out, 1: `byte_o` is valid.
- `byte_ready_i`, in, 1: the sink accepts the byte.
- `busy_o`, out, 1: high in any state other than IDLE.
- `done_o`, out, 1: one-cycle pulse when a run completes.

## Operation
FSM states are IDLE, APPLY, CAPTURE, SEND.
- **IDLE**
  - When `start_i` = 1: latch the mode.
  - Set the current vector to `vec_i` in single mode, or to 0 in sweep mode.
  - Go to APPLY.
  - `start_i` is ignored in all other states.
- **APPLY**
  - `cells_in_o` = current vector.
  - The settle counter loads `SETTLE_CYCLES`-1 on entry and decrements each cycle.
  - At 0, go to CAPTURE.
- **CAPTURE**
  - Register `cells_out_i` into a 73-bit capture register.
  - Clear the byte index to 0 and the running XOR to 0.
  - Go to SEND.
- **SEND** emits a 12-byte frame, in this order:
  - Byte 0 (header) = {2'b10, vector[5:0]}.
  - Bytes 1..9 = capture[7:0], [15:8], … [71:64], least-significant first.
  - Byte 10 = {7'b0, capture[72]}.
  - Byte 11 = XOR of bytes 0..10.
- **End of frame:** after byte 11 is transferred:
  - In sweep mode with vector < 63: increment the vector and go to APPLY.
  - Otherwise: pulse `done_o` and go to IDLE.
- The sweep does not wrap. Vector 63 is the last frame, so a sweep emits exactly 64 frames (768 bytes).
- `cells_in_o` holds its last value through CAPTURE, SEND and IDLE. It changes only on entry to APPLY.
- Reset values:
  - `cells_in_o` = 0, `byte_o` = 0.
  - `byte_valid_o` = 0, `busy_o` = 0, `done_o` = 0.
  - State = IDLE, and the capture register is 0.
- Reset asserted mid-run aborts immediately:
  - No partial-frame completion and no `done_o` pulse.
  - After release the block waits in IDLE for a new `start_i`.

## Timing
- **Start:** `start_i` is sampled at edge 0.
  - APPLY is entered, and `cells_in_o` is valid, after edge 0.
  - Capture occurs at edge `SETTLE_CYCLES`+1.
  - `byte_valid_o` first rises after that edge. Start-to-first-byte latency is therefore `SETTLE_CYCLES`+1 cycles after the start edge.
- **Handshake:**
  - A transfer occurs on any edge where `byte_valid_o` and `byte_ready_i` are both high.
  - Once `byte_valid_o` is raised, it and `byte_o` stay stable until the transfer.
  - With `byte_ready_i` held high, one byte is sent per cycle and `byte_valid_o` stays high for the whole frame.
  - `byte_valid_o` may not depend combinationally on `byte_ready_i`.
- **Frame length:** with ready held high, a frame takes 12 cycles.
- **After the last byte:**
  - Sweep: APPLY is entered on the edge of the last transfer, and `byte_valid_o` is low the next cycle. Per-vector period = `SETTLE_CYCLES` + 1 + 12 cycles.
  - Completion: `done_o` is high for the cycle after the final transfer, and `busy_o` is low in that same cycle.
- A `start_i` in the `done_o` cycle is accepted, because the block is already in IDLE.

## Structure
- Package `cell_tester_pkg` holds:
  - the state enum `tester_state_t`;
  - `FRAME_BYTES` = 12;
  - `HDR_TAG` = 2'b10;
  - `LAST_VEC` = 6'd63;
  - `RESP_W` = 73.
- Sub-module `cell_tester_frame_ser` handles framing. It takes the capture register, the vector and the byte index. It produces the byte mux and the running XOR. It is purely combinational, apart from the XOR accumulator, which updates on each transfer.
- The top level holds the FSM, the settle counter, the vector register, the capture register and the handshake.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-sweep → all outputs 0 immediately. After release, `busy_o` = 0 and no bytes are sent without `start_i`.
- **Single vector:** `vec_i` = 6'h2A, `cells_out_i` = {1'b1, 72'h0123456789ABCDEF01}, ready held high.
  - `cells_in_o` = 6'h2A.
  - Bytes: AA, 01, EF, CD, AB, 89, 67, 45, 23, 01, 01, AA.
  - First valid byte comes 5 cycles after the start edge (`SETTLE_CYCLES` = 4).
  - `done_o` pulses once.
- **Backpressure:** same stimulus, with `byte_ready_i` toggling 1,0,0,1,… → identical byte sequence. `byte_o` is stable while stalled, with no drops or duplicates.
- **Sweep:** `sweep_i` = 1, with `cells_out_i` driven by a model of the cell array → exactly 768 bytes.
  - Headers run 0x80..0xBF in order.
  - Every checksum matches.
  - `cells_in_o` stays at 63 after done.
- **Start while busy:** pulse `start_i` with `vec_i` = 6'h05 during SEND of vector 0x2A → ignored. The frame completes with header AA, and one `done_o`.
- **Settle boundary:** `SETTLE_CYCLES` = 1. Change `cells_out_i` on the cycle after APPLY entry → the capture reflects the new value, and the first byte comes 2 cycles after the start edge.

Source files
------------

// File: rtl/cell_tester_pkg.sv
// Shared types and constants for the cell-array stimulus sequencer and its frame serializer.
package cell_tester_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } tester_state_t;

    localparam int          FRAME_BYTES = 12;
    localparam logic [1:0]  HDR_TAG     = 2'b10;
    localparam logic [5:0]  LAST_VEC    = 6'd63;
    localparam int          RESP_W      = 73;

endpackage

// File: rtl/cell_tester_frame_ser.sv
// Byte mux for one 12-byte response frame plus the running XOR that forms the trailing checksum.
module cell_tester_frame_ser
    import cell_tester_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RESP_W-1:0] capture,
    input  logic [5:0]        vec,
    input  logic [3:0]        idx,
    input  logic              clr,
    input  logic              xfer,
    output logic [7:0]        byte_mux
);

    // Bytes 0..10 laid out back to back: header, nine capture bytes, capture MSB padded.
    logic [87:0] body;
    logic [7:0]  acc;

    assign body = {7'b0, capture, HDR_TAG, vec};

    always_comb begin
        byte_mux = 8'h00;
        if (idx == 4'(FRAME_BYTES - 1))
            byte_mux = acc;
        else if (idx < 4'(FRAME_BYTES - 1))
            byte_mux = body[{idx, 3'b000} +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= 8'h00;
        else if (clr)
            acc <= 8'h00;
        else if (xfer)
            acc <= acc ^ byte_mux;
    end

endmodule

// File: rtl/cell_tester.sv
// Drives a stimulus vector into the cell array, waits the settle time, captures the
// 73-bit response and streams it out as a checksummed byte frame (single vector or full sweep).
module cell_tester
    import cell_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int IN_W          = 6,
    parameter int RESP_W        = 73
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              sweep_i,
    input  logic [IN_W-1:0]   vec_i,
    output logic [IN_W-1:0]   cells_in_o,
    input  logic [RESP_W-1:0] cells_out_i,
    output logic [7:0]        byte_o,
    output logic              byte_valid_o,
    input  logic              byte_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    // Zero is promoted to one so the counter never has to wrap.
    localparam int         SETTLE_EFF  = (SETTLE_CYCLES < 1) ? 1 :
                                         ((SETTLE_CYCLES > 255) ? 255 : SETTLE_CYCLES);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_EFF - 1);

    tester_state_t     state, state_nxt;
    logic              sweep_q;
    logic [5:0]        vec_q;
    logic [7:0]        settle_cnt;
    logic [RESP_W-1:0] capture;
    logic [3:0]        idx;
    logic              done_q;
    logic [7:0]        byte_mux;
    logic              xfer;
    logic              last_byte;
    logic              more_vecs;

    assign byte_valid_o = (state == SEND);
    assign xfer         = byte_valid_o && byte_ready_i;
    assign last_byte    = (idx == 4'(FRAME_BYTES - 1));
    assign more_vecs    = sweep_q && (vec_q != LAST_VEC);

    assign cells_in_o = vec_q;
    assign byte_o     = byte_valid_o ? byte_mux : 8'h00;
    assign busy_o     = (state != IDLE);
    assign done_o     = done_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = APPLY;
            APPLY:   if (settle_cnt == 8'd0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = SEND;
            SEND:    if (xfer && last_byte) state_nxt = more_vecs ? APPLY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sweep_q    <= 1'b0;
            vec_q      <= 6'd0;
            settle_cnt <= 8'd0;
            capture    <= '0;
            idx        <= 4'd0;
            done_q     <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        sweep_q    <= sweep_i;
                        vec_q      <= sweep_i ? 6'd0 : vec_i;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                APPLY: begin
                    if (settle_cnt != 8'd0)
                        settle_cnt <= settle_cnt - 8'd1;
                end
                CAPTURE: begin
                    capture <= cells_out_i;
                    idx     <= 4'd0;
                end
                SEND: begin
                    if (xfer) begin
                        if (!last_byte) begin
                            idx <= idx + 4'd1;
                        end else if (more_vecs) begin
                            vec_q      <= vec_q + 6'd1;
                            settle_cnt <= SETTLE_LOAD;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    cell_tester_frame_ser u_frame_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .capture  (capture),
        .vec      (vec_q),
        .idx      (idx),
        .clr      (state == CAPTURE),
        .xfer     (xfer),
        .byte_mux (byte_mux)
    );

endmodule

// File: tb/tb_cell_tester.sv
// Directed bench for cell_tester: table of single-vector frames, then sweep, reset and settle-boundary sequences.
module tb_cell_tester;

    logic        clk;
    logic        rst_n;
    logic        start_i, sweep_i, byte_ready_i;
    logic [5:0]  vec_i, cells_in_o;
    logic [72:0] cells_out_i, resp_drv;
    logic [7:0]  byte_o;
    logic        byte_valid_o, busy_o, done_o;
    logic        model_en;

    logic        t1_start, t1_ready;
    logic [5:0]  t1_vec, t1_cells_in;
    logic [72:0] t1_cells_out;
    logic [7:0]  t1_byte;
    logic        t1_valid, t1_busy, t1_done;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] got[$];

    typedef struct {
        logic [5:0]  vec;
        logic [72:0] resp;
        int          mode;
        bit          poke;
        logic [95:0] exp;
    } row_t;
    row_t rows[6];

    function automatic logic [72:0] cell_model(input logic [5:0] v);
        return {v[5], {12{v}}};
    endfunction

    function automatic logic [95:0] exp_frame(input logic [5:0] v, input logic [72:0] r);
        logic [7:0]  b[12];
        logic [95:0] f;
        b[0] = {2'b10, v};
        for (int k = 1; k <= 9; k++) b[k] = r[8*(k-1) +: 8];
        b[10] = {7'b0, r[72]};
        b[11] = 8'h00;
        for (int k = 0; k <= 10; k++) b[11] = b[11] ^ b[k];
        for (int k = 0; k < 12; k++) f[95-8*k -: 8] = b[k];
        return f;
    endfunction

    assign cells_out_i = model_en ? cell_model(cells_in_o) : resp_drv;

    cell_tester dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .sweep_i      (sweep_i),
        .vec_i        (vec_i),
        .cells_in_o   (cells_in_o),
        .cells_out_i  (cells_out_i),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .byte_ready_i (byte_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    cell_tester #(.SETTLE_CYCLES(1)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (t1_start),
        .sweep_i      (1'b0),
        .vec_i        (t1_vec),
        .cells_in_o   (t1_cells_in),
        .cells_out_i  (t1_cells_out),
        .byte_o       (t1_byte),
        .byte_valid_o (t1_valid),
        .byte_ready_i (t1_ready),
        .busy_o       (t1_busy),
        .done_o       (t1_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // c counts negedges after the start edge, so c equals cycles since start.
    task automatic run(input logic [5:0] v, input logic sw, input int mode, input bit poke,
                       output int lat, output int dones);
        int         last_x, tail;
        bit         stalled, poked;
        logic [7:0] held;
        got.delete();
        lat = -1; dones = 0; last_x = -10; tail = -1;
        stalled = 0; poked = 0; held = 8'h00;
        @(negedge clk);
        start_i = 1'b1; sweep_i = sw; vec_i = v;
        @(negedge clk);
        for (int c = 0; c < 5000; c++) begin
            start_i = 1'b0;
            byte_ready_i = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            #1;
            if (stalled) check("stall_hold", {byte_valid_o, byte_o}, {1'b1, held});
            stalled = 0;
            if (done_o) begin
                dones++;
                check("done_timing", c, last_x + 1);
                check("done_busy_low", busy_o, 1'b0);
                if (tail < 0) tail = c + 3;
            end
            if (byte_valid_o && lat < 0) lat = c;
            if (byte_valid_o && byte_ready_i) begin
                got.push_back(byte_o);
                last_x = c;
            end else if (byte_valid_o) begin
                stalled = 1;
                held = byte_o;
            end
            if (poke && !poked && got.size() == 3) begin
                start_i = 1'b1; vec_i = 6'h05; sweep_i = 1'b0; poked = 1;
            end
            if (c == tail) break;
            @(negedge clk);
        end
        if (tail < 0) check("run_timeout", 0, 1);
    endtask

    initial begin
        int         lat, dones, bad, guard;
        logic [95:0] f;

        rows[0] = '{6'h2A, {1'b1, 72'h0123456789ABCDEF01}, 0, 1'b0, 96'hAA_01_EF_CD_AB_89_67_45_23_01_01_AA};
        rows[1] = '{6'h2A, {1'b1, 72'h0123456789ABCDEF01}, 1, 1'b0, 96'hAA_01_EF_CD_AB_89_67_45_23_01_01_AA};
        rows[2] = '{6'h2A, {1'b1, 72'h0123456789ABCDEF01}, 0, 1'b1, 96'hAA_01_EF_CD_AB_89_67_45_23_01_01_AA};
        rows[3] = '{6'h00, 73'h0,                          0, 1'b0, 96'h80_00_00_00_00_00_00_00_00_00_00_80};
        rows[4] = '{6'h3F, {73{1'b1}},                     1, 1'b0, 96'hBF_FF_FF_FF_FF_FF_FF_FF_FF_FF_01_41};
        rows[5] = '{6'h15, {1'b0, 72'h800000000000000001}, 0, 1'b0, 96'h95_01_00_00_00_00_00_00_00_80_00_14};

        rst_n = 1'b0; start_i = 1'b0; sweep_i = 1'b0; vec_i = 6'h00;
        byte_ready_i = 1'b1; resp_drv = '0; model_en = 1'b0;
        t1_start = 1'b0; t1_vec = 6'h00; t1_ready = 1'b1; t1_cells_out = '0;
        #1;
        check("reset_outputs", {cells_in_o, byte_o, byte_valid_o, busy_o, done_o}, 17'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {busy_o, byte_valid_o, done_o}, 3'b000);

        for (int r = 0; r < 6; r++) begin
            resp_drv = rows[r].resp;
            run(rows[r].vec, 1'b0, rows[r].mode, rows[r].poke, lat, dones);
            check($sformatf("row%0d_len", r), got.size(), 12);
            for (int k = 0; k < 12; k++) begin
                if (k < got.size())
                    check($sformatf("row%0d_byte%0d", r, k), got[k], rows[r].exp[95-8*k -: 8]);
            end
            check($sformatf("row%0d_latency", r), lat, 5);
            check($sformatf("row%0d_dones", r), dones, 1);
            check($sformatf("row%0d_cells_in", r), cells_in_o, rows[r].vec);
        end

        model_en = 1'b1;
        run(6'h17, 1'b1, 0, 1'b0, lat, dones);
        check("sweep_len", got.size(), 768);
        for (int fr = 0; fr < 64; fr++) begin
            if (got.size() >= 12 * (fr + 1)) begin
                for (int k = 0; k < 12; k++) f[95-8*k -: 8] = got[12*fr + k];
                check($sformatf("sweep_frame%0d", fr), f, exp_frame(6'(fr), cell_model(6'(fr))));
            end
        end
        check("sweep_dones", dones, 1);
        check("sweep_cells_in_end", cells_in_o, 6'd63);

        byte_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b1; sweep_i = 1'b1; vec_i = 6'h00;
        @(negedge clk);
        start_i = 1'b0;
        guard = 0;
        while (!(cells_in_o == 6'd3 && byte_valid_o) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("reset_reach_mid_sweep", guard < 500, 1'b1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_sweep", {cells_in_o, byte_o, byte_valid_o, busy_o, done_o}, 17'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (byte_valid_o || busy_o || done_o) bad++;
        end
        check("no_activity_after_reset", bad, 0);

        @(negedge clk);
        t1_start = 1'b1; t1_vec = 6'h11; t1_cells_out = '0;
        @(negedge clk);
        t1_start = 1'b0;
        check("s1_cells_in", t1_cells_in, 6'h11);
        check("s1_valid_c0", t1_valid, 1'b0);
        @(negedge clk);
        t1_cells_out = {1'b1, 72'hFEDCBA9876543210AB};
        check("s1_valid_c1", t1_valid, 1'b0);
        @(negedge clk);
        check("s1_valid_c2", t1_valid, 1'b1);
        f = 96'h91_AB_10_32_54_76_98_BA_DC_FE_01_3B;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("s1_byte%0d", k), {t1_valid, t1_byte}, {1'b1, f[95-8*k -: 8]});
            @(negedge clk);
        end
        check("s1_done", {t1_done, t1_busy}, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
